// File: rtl/jit_cf_pkg.sv
// Shared types and constants for the JIT control-flow inverse block.
package jit_cf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UNWIND = 2'd1,
        SOLVE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Forward branch increments: a==b adds EQ_OFF, otherwise NE_OFF.
    localparam int EQ_OFF         = 1;
    localparam int NE_OFF         = 2;
    localparam int DEF_LOOP_ITERS = 4;
    localparam int DEF_STEP       = 1;

endpackage

// File: rtl/jit_cf_inv_solve.sv
// Combinational branch resolver: given the pre-loop value x and operand a,
// returns the candidate b and whether zero, one or two solutions exist.
module jit_cf_inv_solve
    import jit_cf_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             found,
    output logic             ambig
);

    logic [WIDTH-1:0] c1;
    logic [WIDTH-1:0] c2;
    logic             v1;
    logic             v2;

    assign c1 = x - a - WIDTH'(EQ_OFF);
    assign c2 = x - a - WIDTH'(NE_OFF);

    // c1 only counts if it really is the equal-branch case; c2 only if it is not.
    assign v1 = (c1 == a);
    assign v2 = (c2 != a);

    assign b     = v1 ? c1 : (v2 ? c2 : '0);
    assign found = v1 | v2;
    assign ambig = v1 & v2;

endmodule

// File: rtl/jit_control_flow_inv.sv
// Sequential inverse of the JIT control-flow datapath: unwinds the
// accumulate loop one step per cycle, then resolves the branch.
module jit_control_flow_inv
    import jit_cf_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LOOP_ITERS = DEF_LOOP_ITERS,
    parameter int STEP       = DEF_STEP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_out,
    input  logic [WIDTH-1:0] in_a,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_b,
    output logic             res_found,
    output logic             res_ambig
);

    localparam int CNT_W = (LOOP_ITERS > 1) ? $clog2(LOOP_ITERS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LOOP_ITERS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] sol_b;
    logic             sol_found;
    logic             sol_ambig;

    jit_cf_inv_solve #(.WIDTH(WIDTH)) u_solve (
        .x     (x_q),
        .a     (a_q),
        .b     (sol_b),
        .found (sol_found),
        .ambig (sol_ambig)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = UNWIND;
            end
            UNWIND:  if (cnt == LAST) state_nxt = SOLVE;
            SOLVE:   state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result registers keep their last value after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            x_q       <= '0;
            a_q       <= '0;
            res_valid <= 1'b0;
            res_b     <= '0;
            res_found <= 1'b0;
            res_ambig <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_q <= in_out;
                        a_q <= in_a;
                        cnt <= '0;
                    end
                end
                UNWIND: begin
                    x_q <= x_q - WIDTH'(STEP);
                    cnt <= cnt + CNT_W'(1);
                end
                SOLVE: begin
                    res_b     <= sol_b;
                    res_found <= sol_found;
                    res_ambig <= sol_ambig;
                    res_valid <= 1'b1;
                end
                DONE: begin
                    if (res_ready) res_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
